// File: rtl/uart_alu_if_if.sv
// Bundle of the rx FIFO, tx FIFO and ALU signals seen by the uart/ALU client.
// The master side is the client; the slave side is the uart block plus the ALU.
interface uart_alu_if_if #(
  parameter int DBIT    = 8,
  parameter int OP_BITS = 6
);
  logic                rx_empty;
  logic [DBIT-1:0]     r_data;
  logic                rd_uart;
  logic                tx_full;
  logic                wr_uart;
  logic [DBIT-1:0]     w_data;
  logic [DBIT-1:0]     alu_a;
  logic [DBIT-1:0]     alu_b;
  logic [OP_BITS-1:0]  alu_op;
  logic [DBIT-1:0]     alu_result;
  logic                frame_done;

  modport master (
    input  rx_empty, r_data, tx_full, alu_result,
    output rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, frame_done
  );

  modport slave (
    output rx_empty, r_data, tx_full, alu_result,
    input  rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, frame_done
  );
endinterface

// File: rtl/uart_alu_if.sv
// Uart client: pops A, B, OP from the rx FIFO, drives the ALU, and pushes the
// registered result into the tx FIFO before waiting for the next frame.
module uart_alu_if #(
  parameter int DBIT    = 8,
  parameter int OP_BITS = 6
) (
  input  logic          clk,
  input  logic          reset,
  uart_alu_if_if.master bus
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_t;

  state_t              state_r;
  logic [DBIT-1:0]     alu_a_r;
  logic [DBIT-1:0]     alu_b_r;
  logic [OP_BITS-1:0]  alu_op_r;
  logic [DBIT-1:0]     w_data_r;
  logic                rd_s;
  logic                wr_s;

  // FIFO strobes follow the flags in the same cycle so no byte or slot is lost
  always_comb begin
    rd_s = 1'b0;
    wr_s = 1'b0;
    if (reset) begin
      rd_s = 1'b0;
      wr_s = 1'b0;
    end else begin
      case (state_r)
        GET_A, GET_B, GET_OP: rd_s = ~bus.rx_empty;
        SEND:                 wr_s = ~bus.tx_full;
        default: begin
          rd_s = 1'b0;
          wr_s = 1'b0;
        end
      endcase
    end
  end

  // Frame sequencer: operand capture, result capture and tx hand-off
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= GET_A;
      alu_a_r  <= {DBIT{1'b0}};
      alu_b_r  <= {DBIT{1'b0}};
      alu_op_r <= {OP_BITS{1'b0}};
      w_data_r <= {DBIT{1'b0}};
    end else begin
      case (state_r)
        GET_A: begin
          if (!bus.rx_empty) begin
            alu_a_r <= bus.r_data;
            state_r <= GET_B;
          end
        end
        GET_B: begin
          if (!bus.rx_empty) begin
            alu_b_r <= bus.r_data;
            state_r <= GET_OP;
          end
        end
        GET_OP: begin
          // only the low opcode bits are meaningful to the ALU
          if (!bus.rx_empty) begin
            alu_op_r <= bus.r_data[OP_BITS-1:0];
            state_r  <= EXEC;
          end
        end
        EXEC: begin
          w_data_r <= bus.alu_result;
          state_r  <= SEND;
        end
        SEND: begin
          if (!bus.tx_full) begin
            state_r <= GET_A;
          end
        end
        default: state_r <= GET_A;
      endcase
    end
  end

  assign bus.rd_uart    = rd_s;
  assign bus.wr_uart    = wr_s;
  assign bus.frame_done = wr_s;
  assign bus.w_data     = w_data_r;
  assign bus.alu_a      = alu_a_r;
  assign bus.alu_b      = alu_b_r;
  assign bus.alu_op     = alu_op_r;

endmodule

// File: tb/tb_uart_alu_if.sv
// Scoreboard bench for uart_alu_if: rx FIFO and ALU models drive the DUT,
// a negedge monitor pops expected results whenever wr_uart is seen.
module tb_uart_alu_if;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  int   rd_total;
  int   byte_cnt;
  int   op_cyc;
  bit   tx_full_seen;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] popped;

  uart_alu_if_if #(.DBIT(8), .OP_BITS(6)) bus ();

  uart_alu_if #(.DBIT(8), .OP_BITS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'h20:   alu_f = a + b;
      6'h22:   alu_f = a - b;
      6'h24:   alu_f = a & b;
      6'h25:   alu_f = a | b;
      6'h26:   alu_f = a ^ b;
      6'h03:   alu_f = $unsigned($signed(a) >>> b);
      6'h02:   alu_f = a >> b;
      6'h27:   alu_f = ~(a | b);
      default: alu_f = 8'h00;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

  // rx FIFO model: pop on rd_uart, present head word after the edge
  always @(posedge clk) begin
    if (bus.rd_uart && rx_q.size() > 0) popped = rx_q.pop_front();
    bus.rx_empty <= (rx_q.size() == 0);
    bus.r_data   <= (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  // Monitor: invariants every cycle, scoreboard compare on every tx push
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (reset) begin
      byte_cnt = 0;
      checks++;
      if (bus.rd_uart || bus.wr_uart || bus.frame_done) begin
        failures++;
        $display("FAIL reset_strobes rd=%0b wr=%0b fd=%0b required all 0",
                 bus.rd_uart, bus.wr_uart, bus.frame_done);
      end
    end else begin
      checks++;
      if (bus.rd_uart && bus.wr_uart) begin
        failures++;
        $display("FAIL rd_wr_exclusive at cycle %0d: both strobes 1", cyc);
      end
      checks++;
      if (bus.rd_uart && bus.rx_empty) begin
        failures++;
        $display("FAIL rd_while_empty at cycle %0d", cyc);
      end
      checks++;
      if (bus.wr_uart && bus.tx_full) begin
        failures++;
        $display("FAIL wr_while_full at cycle %0d", cyc);
      end
      checks++;
      if (bus.frame_done !== bus.wr_uart) begin
        failures++;
        $display("FAIL frame_done got %0b required %0b", bus.frame_done, bus.wr_uart);
      end
      if (bus.rd_uart) begin
        rd_total++;
        byte_cnt++;
        if (byte_cnt == 3) begin
          byte_cnt     = 0;
          op_cyc       = cyc;
          tx_full_seen = 1'b0;
        end
      end
      if (bus.tx_full) tx_full_seen = 1'b1;
      if (bus.wr_uart) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write w_data=%02h with empty scoreboard", bus.w_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.w_data !== e) begin
            failures++;
            $display("FAIL result got %02h required %02h", bus.w_data, e);
          end
          if (!tx_full_seen) begin
            checks++;
            if (cyc != op_cyc + 2) begin
              failures++;
              $display("FAIL latency wr at cycle %0d required %0d", cyc, op_cyc + 2);
            end
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] exp);
    rx_q.push_back(a);
    rx_q.push_back(b);
    rx_q.push_back(op);
    exp_q.push_back(exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0) && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    step(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s timeout: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got %02h required %02h", name, got, req);
    end
  endtask

  initial begin
    int rd_start;
    checks       = 0;
    failures     = 0;
    cyc          = 0;
    rd_total     = 0;
    byte_cnt     = 0;
    op_cyc       = 0;
    tx_full_seen = 1'b0;
    reset        = 1'b1;
    bus.tx_full  = 1'b0;
    step(3);
    check8("reset_alu_a", bus.alu_a, 8'h00);
    check8("reset_alu_b", bus.alu_b, 8'h00);
    check8("reset_alu_op", {2'b00, bus.alu_op}, 8'h00);
    check8("reset_w_data", bus.w_data, 8'h00);
    reset = 1'b0;
    step(1);

    // 1: ADD, three pops, latency checked by monitor
    rd_start = rd_total;
    push_frame(8'h05, 8'h03, 8'h20, 8'h08);
    drain("add", 50);
    check8("add_rd_pulses", 8'(rd_total - rd_start), 8'd3);
    check8("add_alu_op", {2'b00, bus.alu_op}, 8'h20);

    // 2: SRA and NOR, plus opcode upper bits ignored
    push_frame(8'h80, 8'h02, 8'h03, 8'hE0);
    drain("sra", 50);
    push_frame(8'h0F, 8'hF0, 8'h27, 8'h00);
    drain("nor", 50);
    push_frame(8'h01, 8'h02, 8'hE0, 8'h03);
    drain("op_upper", 50);
    check8("op_upper_alu_op", {2'b00, bus.alu_op}, 8'h20);
    check8("hold_alu_a", bus.alu_a, 8'h01);

    // 3: bytes separated by 10-cycle gaps
    exp_q.push_back(8'h04);
    rx_q.push_back(8'h07);
    step(10);
    rx_q.push_back(8'h0C);
    step(10);
    rx_q.push_back(8'h24);
    drain("gaps", 50);

    // 4: tx FIFO full for 20 cycles while in SEND
    bus.tx_full = 1'b1;
    push_frame(8'h10, 8'h01, 8'h22, 8'h0F);
    step(25);
    check8("stall_no_write", 8'(exp_q.size()), 8'd1);
    check8("stall_w_data", bus.w_data, 8'h0F);
    bus.tx_full = 1'b0;
    @(negedge clk);
    check8("stall_release_wr", {7'd0, bus.wr_uart}, 8'h01);
    check8("stall_release_fd", {7'd0, bus.frame_done}, 8'h01);
    drain("stall", 50);

    // 5: reset after A and B consumed
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    step(6);
    check8("partial_alu_a", bus.alu_a, 8'h11);
    check8("partial_alu_b", bus.alu_b, 8'h22);
    reset = 1'b1;
    step(2);
    check8("midreset_alu_a", bus.alu_a, 8'h00);
    check8("midreset_alu_b", bus.alu_b, 8'h00);
    check8("midreset_w_data", bus.w_data, 8'h00);
    reset = 1'b0;
    step(1);
    push_frame(8'h0A, 8'h04, 8'h22, 8'h06);
    drain("after_reset", 50);

    // 6: six frames queued back-to-back
    push_frame(8'hFF, 8'h01, 8'h20, 8'h00);
    push_frame(8'h00, 8'h01, 8'h22, 8'hFF);
    push_frame(8'h30, 8'h0C, 8'h25, 8'h3C);
    push_frame(8'hAA, 8'hFF, 8'h26, 8'h55);
    push_frame(8'h80, 8'h03, 8'h02, 8'h10);
    push_frame(8'hF0, 8'h01, 8'h03, 8'hF8);
    drain("burst", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
